// File: rtl/ps2_kbd_if.sv
// Bundle of command, scancode, LED-request and status signals between the PS/2
// keyboard controller and its surroundings (transceiver and host registers).
interface ps2_kbd_if;
  logic       o_cmd_val;
  logic [7:0] o_cmd;
  logic       i_tx_ready;
  logic       i_scan_val;
  logic [7:0] i_scancode;
  logic       i_led_val;
  logic [2:0] i_led;
  logic       o_led_busy;
  logic [7:0] o_joy;
  logic       o_init_done;
  logic       o_kbd_err;

  modport master (
    output o_cmd_val, o_cmd, o_led_busy, o_joy, o_init_done, o_kbd_err,
    input  i_tx_ready, i_scan_val, i_scancode, i_led_val, i_led
  );

  modport slave (
    input  o_cmd_val, o_cmd, o_led_busy, o_joy, o_init_done, o_kbd_err,
    output i_tx_ready, i_scan_val, i_scancode, i_led_val, i_led
  );
endinterface

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard sequencer: reset/BAT/LED init with retry+timeout, LED update
// serialisation, and make/break/extended scancode decode into a joypad vector.
module ps2_kbd_ctrl #(
  parameter logic [23:0] TIMEOUT_CYC = 24'd2400000,
  parameter int          MAX_RETRY   = 2
) (
  input  logic      i_clk,
  input  logic      i_rstn,
  ps2_kbd_if.master bus
);
  typedef enum logic [2:0] {
    S_RST_TX, S_RST_WAIT, S_BAT_WAIT, S_LED_TX,
    S_LED_WAIT, S_LEDV_TX, S_LEDV_WAIT, S_RUN
  } state_t;

  localparam logic [3:0] LP_MAX_RETRY = 4'(MAX_RETRY);

  state_t      r_state, w_next, w_owner;
  logic        r_armed, r_scan_d, r_init_done, r_kbd_err;
  logic [3:0]  r_retry;
  logic [23:0] r_timer;
  logic [2:0]  r_led_latch;
  logic        r_ext, r_brk, r_hit, r_val;
  logic [2:0]  r_idx;
  logic [7:0]  r_joy;
  logic        w_rx_evt, w_is_tx, w_is_wait, w_timeout, w_cmd_val;
  logic        w_ok, w_fail, w_retry_inc, w_retry_clr, w_err_set, w_led_acc;
  logic [7:0]  w_cmd_byte, w_byte;
  logic [3:0]  w_lk;

  // {hit, bit index} for a scancode given the extended-prefix flag
  function automatic logic [3:0] key_lookup(input logic ext, input logic [7:0] code);
    logic [3:0] res;
    res = 4'b0000;
    if (!ext) begin
      case (code)
        8'h42:   res = {1'b1, 3'd0};
        8'h3B:   res = {1'b1, 3'd1};
        8'h29:   res = {1'b1, 3'd2};
        8'h5A:   res = {1'b1, 3'd3};
        default: res = 4'b0000;
      endcase
    end else begin
      case (code)
        8'h75:   res = {1'b1, 3'd4};
        8'h72:   res = {1'b1, 3'd5};
        8'h6B:   res = {1'b1, 3'd6};
        8'h74:   res = {1'b1, 3'd7};
        default: res = 4'b0000;
      endcase
    end
    return res;
  endfunction

  assign w_byte    = bus.i_scancode;
  assign w_rx_evt  = bus.i_scan_val & ~r_scan_d;
  assign w_is_tx   = (r_state == S_RST_TX) || (r_state == S_LED_TX) || (r_state == S_LEDV_TX);
  assign w_is_wait = (r_state == S_RST_WAIT) || (r_state == S_BAT_WAIT) ||
                     (r_state == S_LED_WAIT) || (r_state == S_LEDV_WAIT);
  assign w_timeout = w_is_wait && (r_timer >= TIMEOUT_CYC);
  // r_armed keeps the strobe low in the first cycle out of reset
  assign w_cmd_val = r_armed & bus.i_tx_ready & w_is_tx;
  assign w_led_acc = (r_state == S_RUN) & bus.i_led_val;
  assign w_lk      = key_lookup(r_ext, w_byte);

  always_comb begin
    w_cmd_byte = 8'h00;
    case (r_state)
      S_RST_TX:  w_cmd_byte = 8'hFF;
      S_LED_TX:  w_cmd_byte = 8'hED;
      S_LEDV_TX: w_cmd_byte = {5'b0, r_led_latch};
      default:   w_cmd_byte = 8'h00;
    endcase
  end

  assign bus.o_cmd_val   = w_cmd_val;
  assign bus.o_cmd       = w_cmd_val ? w_cmd_byte : 8'h00;
  assign bus.o_led_busy  = (r_state != S_RUN);
  assign bus.o_joy       = r_joy;
  assign bus.o_init_done = r_init_done;
  assign bus.o_kbd_err   = r_kbd_err;

  always_comb begin
    w_next      = r_state;
    w_owner     = S_RST_TX;
    w_ok        = 1'b0;
    w_fail      = 1'b0;
    w_retry_inc = 1'b0;
    w_retry_clr = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      S_RST_TX:  if (w_cmd_val) w_next = S_RST_WAIT;
      S_RST_WAIT: begin
        w_owner = S_RST_TX;
        if (w_rx_evt) begin
          if (w_byte == 8'hFA) begin w_ok = 1'b1; w_next = S_BAT_WAIT; end
          else w_fail = 1'b1;
        end else if (w_timeout) w_fail = 1'b1;
      end
      S_BAT_WAIT: begin
        w_owner = S_RST_TX;
        if (w_rx_evt) begin
          if (w_byte == 8'hAA) begin w_ok = 1'b1; w_next = S_LED_TX; end
          else if (w_byte == 8'hFC || w_byte == 8'hFE) w_fail = 1'b1;
        end else if (w_timeout) w_fail = 1'b1;
      end
      S_LED_TX:  if (w_cmd_val) w_next = S_LED_WAIT;
      S_LED_WAIT: begin
        w_owner = S_LED_TX;
        if (w_rx_evt) begin
          if (w_byte == 8'hFA) begin w_ok = 1'b1; w_next = S_LEDV_TX; end
          else w_fail = 1'b1;
        end else if (w_timeout) w_fail = 1'b1;
      end
      S_LEDV_TX: if (w_cmd_val) w_next = S_LEDV_WAIT;
      S_LEDV_WAIT: begin
        w_owner = S_LED_TX;
        if (w_rx_evt) begin
          if (w_byte == 8'hFA) begin w_ok = 1'b1; w_next = S_RUN; end
          else w_fail = 1'b1;
        end else if (w_timeout) w_fail = 1'b1;
      end
      S_RUN:     if (w_led_acc) w_next = S_LED_TX;
      default:   w_next = S_RST_TX;
    endcase
    if (w_fail) begin
      if (r_retry < LP_MAX_RETRY) begin
        w_retry_inc = 1'b1;
        w_next      = w_owner;
      end else begin
        w_err_set   = 1'b1;
        w_retry_clr = 1'b1;
        w_next      = S_RUN;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state     <= S_RST_TX;
      r_armed     <= 1'b0;
      r_scan_d    <= 1'b0;
      r_init_done <= 1'b0;
      r_kbd_err   <= 1'b0;
      r_retry     <= 4'd0;
      r_timer     <= 24'd0;
      r_led_latch <= 3'd0;
    end else begin
      r_state  <= w_next;
      r_armed  <= 1'b1;
      r_scan_d <= bus.i_scan_val;
      if (w_next == S_RUN) r_init_done <= 1'b1;
      if (w_err_set)       r_kbd_err   <= 1'b1;
      if (w_ok || w_retry_clr) r_retry <= 4'd0;
      else if (w_retry_inc)    r_retry <= r_retry + 4'd1;
      if ((w_next != r_state) || w_rx_evt) r_timer <= 24'd0;
      else if (w_is_wait)                  r_timer <= r_timer + 24'd1;
      if (w_led_acc) r_led_latch <= bus.i_led;
    end
  end

  // Decode stage registers the lookup; the joypad bit lands one cycle later
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_ext <= 1'b0;
      r_brk <= 1'b0;
      r_hit <= 1'b0;
      r_val <= 1'b0;
      r_idx <= 3'd0;
      r_joy <= 8'h00;
    end else begin
      r_hit <= 1'b0;
      if ((r_state == S_RUN) && w_rx_evt) begin
        case (w_byte)
          8'hE0:               r_ext <= 1'b1;
          8'hF0:               r_brk <= 1'b1;
          8'hFA, 8'hAA, 8'hFE: ;
          default: begin
            r_ext <= 1'b0;
            r_brk <= 1'b0;
            r_hit <= w_lk[3];
            r_idx <= w_lk[2:0];
            r_val <= ~r_brk;
          end
        endcase
      end
      if (r_hit) r_joy[r_idx] <= r_val;
    end
  end
endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Scoreboard bench for ps2_kbd_ctrl: expected command bytes and joypad values are
// queued by the stimulus thread and checked by a monitor as the DUT produces them.
module tb_ps2_kbd_ctrl;
  localparam logic [23:0] T = 24'd40;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  ps2_kbd_if bus();

  ps2_kbd_ctrl #(.TIMEOUT_CYC(T), .MAX_RETRY(2)) dut (
    .i_clk (clk),
    .i_rstn(rstn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0, cyc = 0;
  int cmd_seen = 0, cmd_tgt = 0, last_cmd_cyc = 0, prev_cmd_cyc = 0;
  logic [7:0] exp_cmd[$];
  logic [7:0] exp_joy[$];
  logic [7:0] joy_prev = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever a command strobe or joypad change appears
  always @(negedge clk) begin
    if (bus.o_cmd_val === 1'b1) begin
      prev_cmd_cyc = last_cmd_cyc;
      last_cmd_cyc = cyc;
      cmd_seen++;
      if (exp_cmd.size() == 0) begin
        checks++; errors++;
        $display("FAIL cmd_unexpected: got %0h expected none", bus.o_cmd);
      end else chk("cmd", {24'd0, bus.o_cmd}, {24'd0, exp_cmd.pop_front()});
    end
    if (bus.o_joy !== joy_prev) begin
      if (exp_joy.size() == 0) begin
        checks++; errors++;
        $display("FAIL joy_unexpected: got %0h expected %0h", bus.o_joy, joy_prev);
      end else chk("joy", {24'd0, bus.o_joy}, {24'd0, exp_joy.pop_front()});
      joy_prev = bus.o_joy;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_cmds(input int n, input int budget);
    cmd_tgt += n;
    for (int i = 0; i < budget && cmd_seen < cmd_tgt; i++) begin
      @(negedge clk); #1;
    end
    if (cmd_seen < cmd_tgt) begin
      checks++; errors++;
      $display("FAIL cmd_wait_timeout: got %0d strobes expected %0d", cmd_seen, cmd_tgt);
      cmd_tgt = cmd_seen;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    @(posedge clk); #1;
    bus.i_scancode = b;
    bus.i_scan_val = 1'b1;
    tick(hold);
    bus.i_scan_val = 1'b0;
    tick(2);
  endtask

  task automatic pulse_led(input logic [2:0] l);
    @(posedge clk); #1;
    bus.i_led     = l;
    bus.i_led_val = 1'b1;
    tick(1);
    bus.i_led_val = 1'b0;
  endtask

  task automatic chk_status(input string tag, input logic done, input logic err, input logic busy);
    chk({tag, "_init_done"}, {31'd0, bus.o_init_done}, {31'd0, done});
    chk({tag, "_kbd_err"},   {31'd0, bus.o_kbd_err},   {31'd0, err});
    chk({tag, "_led_busy"},  {31'd0, bus.o_led_busy},  {31'd0, busy});
  endtask

  initial begin
    bus.i_tx_ready = 1'b1;
    bus.i_scan_val = 1'b0;
    bus.i_scancode = 8'h00;
    bus.i_led_val  = 1'b0;
    bus.i_led      = 3'b000;
    #1 rstn = 1'b0;
    tick(3);
    chk("rst_cmd_val", {31'd0, bus.o_cmd_val}, 32'd0);
    chk("rst_cmd", {24'd0, bus.o_cmd}, 32'd0);
    chk("rst_joy", {24'd0, bus.o_joy}, 32'd0);
    chk_status("rst", 1'b0, 1'b0, 1'b1);

    // Normal init: FF -> FA, AA; ED -> FA; 00 -> FA
    exp_cmd.push_back(8'hFF); exp_cmd.push_back(8'hED); exp_cmd.push_back(8'h00);
    rstn = 1'b1;
    wait_cmds(1, 20);
    send_byte(8'hFA, 1);
    send_byte(8'hAA, 1);
    wait_cmds(1, 20);
    send_byte(8'hFA, 1);
    wait_cmds(1, 20);
    send_byte(8'hFA, 1);
    tick(3);
    chk_status("init", 1'b1, 1'b0, 1'b0);

    // Scancode decode
    exp_joy.push_back(8'h10);
    send_byte(8'hE0, 1); send_byte(8'h75, 1);
    exp_joy.push_back(8'h00);
    send_byte(8'hE0, 1); send_byte(8'hF0, 1); send_byte(8'h75, 1);
    exp_joy.push_back(8'h01);
    send_byte(8'h42, 1);
    exp_joy.push_back(8'h00);
    send_byte(8'hF0, 1); send_byte(8'h42, 1);
    send_byte(8'h75, 1);
    tick(3);
    chk("nonext_75_ignored", {24'd0, bus.o_joy}, 32'd0);
    exp_joy.push_back(8'h08);
    send_byte(8'h5A, 10);
    tick(2);
    chk("held_start", {24'd0, bus.o_joy}, 32'h08);
    exp_joy.push_back(8'h00);
    send_byte(8'hF0, 1); send_byte(8'h5A, 1);
    tick(2);

    // LED update, dropped second request, FE on value byte
    exp_cmd.push_back(8'hED); exp_cmd.push_back(8'h05);
    exp_cmd.push_back(8'hED); exp_cmd.push_back(8'h05);
    pulse_led(3'b101);
    wait_cmds(1, 20);
    tick(1);
    chk("led_busy_during_update", {31'd0, bus.o_led_busy}, 32'd1);
    pulse_led(3'b010);
    send_byte(8'hFA, 1);
    wait_cmds(1, 20);
    send_byte(8'hFE, 1);
    wait_cmds(1, 20);
    send_byte(8'hFA, 1);
    wait_cmds(1, 20);
    send_byte(8'hFA, 1);
    tick(3);
    chk_status("led", 1'b1, 1'b0, 1'b0);

    // Joy 81 preserved across LED update, then async reset in LEDV_WAIT
    exp_joy.push_back(8'h01);
    send_byte(8'h42, 1);
    exp_joy.push_back(8'h81);
    send_byte(8'hE0, 1); send_byte(8'h74, 1);
    exp_cmd.push_back(8'hED); exp_cmd.push_back(8'h05);
    pulse_led(3'b101);
    wait_cmds(1, 20);
    send_byte(8'hFA, 1);
    wait_cmds(1, 20);
    tick(2);
    chk("joy_kept_in_ledv_wait", {24'd0, bus.o_joy}, 32'h81);
    exp_joy.push_back(8'h00);
    rstn = 1'b0;
    #1;
    chk("rst_mid_joy", {24'd0, bus.o_joy}, 32'd0);
    chk("rst_mid_cmd_val", {31'd0, bus.o_cmd_val}, 32'd0);
    chk_status("rst_mid", 1'b0, 1'b0, 1'b1);
    tick(2);
    exp_cmd.push_back(8'hFF); exp_cmd.push_back(8'hED); exp_cmd.push_back(8'h00);
    rstn = 1'b1;
    wait_cmds(1, 20);
    send_byte(8'hFA, 1);
    send_byte(8'hAA, 1);
    wait_cmds(1, 20);
    send_byte(8'hFA, 1);
    wait_cmds(1, 20);
    send_byte(8'hFA, 1);
    tick(3);
    chk_status("reinit", 1'b1, 1'b0, 1'b0);

    // Silent keyboard: FF sent 1 + MAX_RETRY times, then give up
    rstn = 1'b0;
    tick(2);
    exp_cmd.push_back(8'hFF); exp_cmd.push_back(8'hFF); exp_cmd.push_back(8'hFF);
    rstn = 1'b1;
    wait_cmds(1, 20);
    for (int k = 0; k < 2; k++) begin
      wait_cmds(1, 2 * int'(T) + 20);
      chk("retry_gap_in_range",
          {31'd0, ((last_cmd_cyc - prev_cmd_cyc) >= int'(T)) &&
                  ((last_cmd_cyc - prev_cmd_cyc) <= int'(T) + 3)}, 32'd1);
    end
    tick(int'(T) + 10);
    chk_status("giveup", 1'b1, 1'b1, 1'b0);

    tick(5);
    chk("cmd_queue_drained", exp_cmd.size(), 32'd0);
    chk("joy_queue_drained", exp_joy.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/ps2_kbd_ctrl.md
Name: ps2_kbd_ctrl

Overview:
- Sequencer and decoder that sits between the PS/2 transceiver and the device manager's joypad registers.
- After reset it initialises the keyboard: reset command 0xFF, wait for ACK 0xFA, wait for BAT 0xAA, then LED set 0xED + value.
- It then decodes make/break/extended scancode streams into an 8-bit NES joypad button vector.
- It serialises host LED-update requests onto the transceiver command port, with retry and timeout.

Parameters:
TIMEOUT_CYC, 24'd2400000, cycles to wait for any keyboard response byte before retrying.
MAX_RETRY, 2, resends per command before giving up (flags error, proceeds).

Ports:
i_clk  in  1  system clock
i_rstn  in  1  asynchronous active-low reset
o_cmd_val  out  1  one-cycle command strobe to transceiver
o_cmd  out  8  command byte, valid with o_cmd_val
i_tx_ready  in  1  transceiver idle (its ready output)
i_scan_val  in  1  transceiver scancode valid; level, may stay high several cycles per byte
i_scancode  in  8  received byte, valid while i_scan_val=1
i_led_val  in  1  host LED update request pulse
i_led  in  3  {caps,num,scroll} LED bits
o_led_busy  out  1  LED request cannot be accepted
o_joy  out  8  button state: [0]A [1]B [2]Select [3]Start [4]Up [5]Down [6]Left [7]Right, 1 = pressed
o_init_done  out  1  init sequence finished (success or give-up)
o_kbd_err  out  1  sticky: a command exhausted MAX_RETRY

Behaviour:
- Reset (async, any state): all outputs 0 except o_led_busy=1; state=S_RST_TX; flags, retry count, timer, LED latch all cleared.
- Byte event (rx_evt) = rising edge of i_scan_val, via a 1-cycle registered copy; exactly one event per byte, data = i_scancode that cycle.
- Command issue: in any *_TX state, o_cmd_val=1 for one cycle only when i_tx_ready=1; next cycle the state goes to its *_WAIT state and the timer is cleared. While i_tx_ready=0 the TX state holds with no strobe.
- Timer: 24-bit, counts in *_WAIT states, cleared on state entry and on every rx_evt. Reaching TIMEOUT_CYC counts as a timeout.
- FSM:
  - S_RST_TX sends 0xFF -> S_RST_WAIT.
  - S_RST_WAIT: 0xFA -> S_BAT_WAIT (retry count cleared).
  - S_BAT_WAIT: 0xAA -> S_LED_TX. 0xFC, or timeout -> retry path.
  - S_LED_TX sends 0xED -> S_LED_WAIT.
  - S_LED_WAIT: 0xFA -> S_LEDV_TX.
  - S_LEDV_TX sends {5'b0,led_latch} -> S_LEDV_WAIT.
  - S_LEDV_WAIT: 0xFA -> S_RUN; o_init_done set on first arrival and stays 1.
  - S_RUN: accepted i_led_val -> S_LED_TX.
- Retry path (any WAIT state): 0xFE, timeout, or any byte other than the expected one (except in S_BAT_WAIT, which ignores other bytes).
  - If retry count < MAX_RETRY: increment it and go back to the owning TX state. For S_BAT_WAIT and S_LEDV_WAIT the owning TX state is S_RST_TX and S_LED_TX respectively.
  - Otherwise: o_kbd_err<=1, retry count cleared, go to S_RUN.
- Retry count clears on every successful ACK.
- LED requests:
  - o_led_busy = (state != S_RUN).
  - In S_RUN, i_led_val latches i_led into led_latch. A request while busy is dropped.
  - A pulse coincident with an rx_evt in S_RUN is accepted; the byte is still decoded that cycle.
- Decoder, active only in S_RUN:
  - 0xE0 sets ext; 0xF0 sets brk.
  - 0xFA, 0xAA and 0xFE are discarded with flags unchanged.
  - Any other byte is looked up with ext. On a match the mapped o_joy bit is set to ~brk on the following cycle. ext and brk both clear after any non-prefix byte, matched or not.
- Key map:
  - non-ext: 0x42 -> A, 0x3B -> B, 0x29 -> Select, 0x5A -> Start
  - ext: 0x75 -> Up, 0x72 -> Down, 0x6B -> Left, 0x74 -> Right
  - Non-ext 0x75 and the other arrow codes without E0 are ignored.
- Leaving S_RUN for an LED update preserves o_joy. Bytes arriving in LED WAIT states are handled only as responses, not decoded.
- Latencies: rx_evt to o_joy update = 2 cycles after the i_scan_val rising edge; i_tx_ready to o_cmd_val = 0 cycles (combinational gate on registered state).

Test Plan:
- Reset release, i_tx_ready=1, model replies FA, AA, FA, FA → o_cmd sequence FF, ED, 00; o_init_done=1; o_kbd_err=0; o_led_busy=0.
- In RUN, bytes E0 75 → o_joy=8'h10; then E0 F0 75 → o_joy=8'h00. Byte 42 → bit0 set; F0 42 → cleared. Non-ext 75 → o_joy unchanged.
- i_scan_val held high 10 cycles for byte 5A → o_joy[3] set once; a following F0 5A clears it. No double event.
- Keyboard silent after FF → FF sent 3 times (1 + MAX_RETRY), each TIMEOUT_CYC apart; then o_kbd_err=1, o_init_done=1, state RUN.
- In RUN, i_led_val with i_led=3'b101 → o_cmd ED then 05 after each FA. A second i_led_val during busy is dropped. Reply FE to 05 → 05 resent.
- Assert i_rstn low mid S_LEDV_WAIT with o_joy=8'h81 → all outputs cleared immediately, o_led_busy=1; the init sequence restarts with FF after release.
